// File: rtl/serial_sub4_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SUB_WIDTH = 4;
  localparam int SUB_IDX_W = $clog2(SUB_WIDTH);

endpackage

// File: rtl/serial_sub4_if.sv
// Operand/result handshake bundle for serial_sub4.
interface serial_sub4_if
  import serial_sub4_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             c;
  logic             v;
  logic             z;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, c, v, z
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, c, v, z
  );
endinterface

// File: rtl/serial_sub4_fa_cell.sv
// Combinational 1-bit full adder shared by every serial bit step.
module fa_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = x_i ^ y_i ^ ci_i;
  assign co_o = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
endmodule

// File: rtl/serial_sub4.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, one bit per clock.
// Optional build macro SERIAL_SUB4_SAT_EN saturates d on signed overflow.
module serial_sub4
  import serial_sub4_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub4_if.slave bus
);
  localparam int IW = (WIDTH == SUB_WIDTH) ? SUB_IDX_W : $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d, v_q, v_d, z_q, z_d;
  logic             sum, cout;
  logic [WIDTH-1:0] d_run;

  fa_cell u_fa (
    .x_i  (a_q[0]),
    .y_i  (~b_q[0]),
    .ci_i (carry_q),
    .s_o  (sum),
    .co_o (cout)
  );

  // Sum bits enter at the MSB so the word is aligned after WIDTH steps.
  assign d_run = {sum, d_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cout;
        d_d     = d_run;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // carry_q here is the carry into the MSB.
          c_d   = cout;
          v_d   = cout ^ carry_q;
`ifdef SERIAL_SUB4_SAT_EN
          if (cout ^ carry_q) begin
            d_d = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
          z_d     = (d_d == '0);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.d         = d_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed self-checking bench for serial_sub4 with hand-computed expectations.
module tb_serial_sub4;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_sub4_if #(.WIDTH(4)) bus ();

  serial_sub4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] av, input logic [3:0] bv);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [3:0] ed, input logic ec,
                           input logic ev, input logic ez);
    chk({tag, "_d"}, 32'(bus.d), 32'(ed));
    chk({tag, "_c"}, 32'(bus.c), 32'(ec));
    chk({tag, "_v"}, 32'(bus.v), 32'(ev));
    chk({tag, "_z"}, 32'(bus.z), 32'(ez));
  endtask

  task automatic release_op(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] ed, input logic ec, input logic ev, input logic ez);
    start_op(av, bv);
    wait_done(tag);
    check_res(tag, ed, ec, ev, ez);
    release_op(tag);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_res("rst", 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("5m3", 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_op("3m5", 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_SUB4_SAT_EN
    run_op("7mm1", 4'b0111, 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b0);
    run_op("m8m1", 4'b1000, 4'b0001, 4'b1000, 1'b1, 1'b1, 1'b0);
`else
    run_op("7mm1", 4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0);
    run_op("m8m1", 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0);
`endif

    // Equal operands, then backpressure with input noise.
    start_op(4'b1010, 4'b1010);
    wait_done("eq");
    check_res("eq", 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.a        = 4'(k * 5 + 3);
      bus.b        = 4'(k + 1);
      bus.in_valid = k[0] ? 1'b0 : 1'b1;
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_res("bp", 4'b0000, 1'b1, 1'b0, 1'b1);
    end
    bus.in_valid = 1'b0;
    release_op("eq");

    // Reset two cycles into RUN abandons the operation.
    start_op(4'b0101, 4'b0011);
    tick();
    tick();
    chk("mid_out_valid_pre", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_d", 32'(bus.d), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("6m2", 4'b0110, 4'b0010, 4'b0100, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
